// File: rtl/da_shift_accumulator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : da_shift_accumulator_pkg
// Description : Shared definitions for the DA shift-accumulate stage of the
//               8-point DCT: FSM state encoding, counter-width and
//               accumulator-width helpers. The ROM and transpose stages use
//               the same width derivation.
// Revision    : 1.0 - initial release
// ============================================================================
package da_shift_accumulator_pkg;

  // FSM state encoding, shared across the DCT stages
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Width of a counter that must hold the values 0 .. n-1 (n >= 2)
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Accumulator width: partial product plus one growth bit per bit-plane
  function automatic int acc_width(input int pp_w, input int in_b);
    return pp_w + in_b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/da_shift_accumulator_cla_adder.sv
`default_nettype none
// ============================================================================
// Module      : cla_adder
// Description : Parallel-prefix (Kogge-Stone style) carry-lookahead adder.
//               sum = a + b + cin, modulo 2^WIDTH; cout is the carry out.
// Ports       : a, b   - WIDTH-bit operands
//               cin    - carry in
//               sum    - WIDTH-bit result
//               cout   - carry out of the MSB
// Revision    : 1.0 - initial release
// ============================================================================
module cla_adder #(
  parameter int WIDTH = 21
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] w_gpre;   // group generate over bits [i:0]
  logic [WIDTH-1:0] w_ppre;   // group propagate over bits [i:0]
  logic [WIDTH:0]   w_carry;  // carry into each bit, plus carry out

  // Prefix tree: each level combines (G,P) of bit i with bit i-2^l. Bits
  // below 2^l see zeros shifted in for G (unchanged) and ones for P
  // (unchanged), so they simply pass through.
  always_comb begin
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    g = a & b;
    p = a ^ b;
    for (int l = 0; l < LEVELS; l++) begin
      g = g | (p & (g << (1 << l)));
      p = p & ~((~p) << (1 << l));
    end
    w_gpre = g;
    w_ppre = p;
  end

  // Carry into bit i+1 = G[i:0] | (P[i:0] & cin)
  assign w_carry = {w_gpre | (w_ppre & {WIDTH{cin}}), cin};
  assign sum     = (a ^ b) ^ w_carry[WIDTH-1:0];
  assign cout    = w_carry[WIDTH];

endmodule
`default_nettype wire

// File: rtl/da_shift_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : da_shift_accumulator
// Description : Distributed-arithmetic shift-accumulate stage of the
//               memory-based 8-point DCT. Takes one signed ROM partial
//               product per input bit-plane (MSB/sign plane first) and emits
//               one signed coefficient every IN_BITS accepted beats:
//                 out = sum_j P_j*2^j - 2*P_{B-1}*2^{B-1}
//               i.e. the sign plane carries negative weight.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               in_valid/in_ready   - partial product handshake
//               in_pp               - signed partial product (PP_WIDTH)
//               out_valid/out_ready - result handshake
//               out_data            - signed coefficient (ACC_W)
// Revision    : 1.0 - initial release
// ============================================================================
module da_shift_accumulator
  import da_shift_accumulator_pkg::*;
#(
  parameter  int PP_WIDTH = 12,
  parameter  int IN_BITS  = 9,
  localparam int ACC_W    = acc_width(PP_WIDTH, IN_BITS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PP_WIDTH-1:0] in_pp,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_W-1:0]    out_data
);

  localparam int               CW         = cnt_width(IN_BITS);
  localparam logic [CW-1:0]    C_CNT_LAST = CW'(IN_BITS - 1);
  localparam logic [CW-1:0]    C_CNT_ONE  = CW'(1);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [ACC_W-1:0] r_acc;

  logic             w_accept;
  logic             w_first;
  logic [ACC_W-1:0] w_sext;
  logic [ACC_W-1:0] w_op_a;
  logic [ACC_W-1:0] w_op_b;
  logic [ACC_W-1:0] w_sum;
  logic             w_cout_unused;

  // In DONE the stage only takes a new beat if the result leaves this cycle
  assign in_ready = (r_state == DONE) ? out_ready : 1'b1;
  assign w_accept = in_valid & in_ready;

  // Any beat accepted outside ACCUM is the sign plane of a new coefficient
  assign w_first = (r_state != ACCUM);
  assign w_sext  = {{IN_BITS{in_pp[PP_WIDTH-1]}}, in_pp};

  // Sign plane: 0 + ~x + 1 = -x. Other planes: (acc << 1) + x.
  assign w_op_a = w_first ? '0 : {r_acc[ACC_W-2:0], 1'b0};
  assign w_op_b = w_first ? ~w_sext : w_sext;

  cla_adder #(
    .WIDTH (ACC_W)
  ) u_cla_adder (
    .a    (w_op_a),
    .b    (w_op_b),
    .cin  (w_first),
    .sum  (w_sum),
    .cout (w_cout_unused)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_acc   <= w_sum;
            r_cnt   <= C_CNT_ONE;
            r_state <= ACCUM;
          end
        end
        ACCUM: begin
          if (w_accept) begin
            r_acc <= w_sum;
            if (r_cnt == C_CNT_LAST) begin
              out_data  <= w_sum;
              out_valid <= 1'b1;
              r_cnt     <= '0;
              r_state   <= DONE;
            end else begin
              r_cnt <= r_cnt + C_CNT_ONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              // Result leaves and the next sign plane arrives together
              r_acc   <= w_sum;
              r_cnt   <= C_CNT_ONE;
              r_state <= ACCUM;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_state   <= IDLE;
          r_cnt     <= '0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_da_shift_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_da_shift_accumulator
// Description : Self-checking bench for da_shift_accumulator. One instance
//               uses IN_BITS=4, a second uses the default IN_BITS=9. Expected
//               coefficients come from a plain-arithmetic weighted-sum model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_da_shift_accumulator;

  localparam int PPW = 12;
  localparam int NB4 = 4;
  localparam int NB9 = 9;
  localparam int AW4 = PPW + NB4;
  localparam int AW9 = PPW + NB9;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic           in_valid4, in_ready4, out_valid4, out_ready4;
  logic [PPW-1:0] in_pp4;
  logic [AW4-1:0] out_data4;
  logic           in_valid9, in_ready9, out_valid9, out_ready9;
  logic [PPW-1:0] in_pp9;
  logic [AW9-1:0] out_data9;

  int errors = 0;
  int checks = 0;

  da_shift_accumulator #(.PP_WIDTH(PPW), .IN_BITS(NB4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_pp(in_pp4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4)
  );

  da_shift_accumulator #(.PP_WIDTH(PPW)) dut9 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid9), .in_ready(in_ready9), .in_pp(in_pp9),
    .out_valid(out_valid9), .out_ready(out_ready9), .out_data(out_data9)
  );

  // Reference: beats arrive MSB plane first; the sign plane has weight
  // -2^(nb-1), every other plane j has weight +2^j.
  function automatic int da_ref(input int beats[$], input int nb);
    int s;
    int j;
    s = 0;
    for (int k = 0; k < nb; k++) begin
      j = nb - 1 - k;
      if (k == 0) s = s - beats[k] * (1 << j);
      else        s = s + beats[k] * (1 << j);
    end
    return s;
  endfunction

  function automatic int rand_pp();
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send4(input int v);
    in_valid4 = 1'b1;
    in_pp4    = PPW'(v);
    tick();
  endtask

  task automatic send9(input int v);
    in_valid9 = 1'b1;
    in_pp9    = PPW'(v);
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid4 = 1'b0; in_pp4 = '0; out_ready4 = 1'b1;
    in_valid9 = 1'b0; in_pp9 = '0; out_ready9 = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL reset_out_valid4: got %b expected 0", out_valid4); end
    checks++; if (out_data4 !== '0) begin errors++; $display("FAIL reset_out_data4: got %h expected 0", out_data4); end
    checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL reset_in_ready4: got %b expected 1", in_ready4); end
    checks++; if (out_valid9 !== 1'b0) begin errors++; $display("FAIL reset_out_valid9: got %b expected 0", out_valid9); end
    checks++; if (out_data9 !== '0) begin errors++; $display("FAIL reset_out_data9: got %h expected 0", out_data9); end
  endtask

  task automatic test_basic();
    int q[$];
    logic [AW4-1:0] exp;
    q = '{3, 1, 0, 2};
    exp = AW4'(da_ref(q, NB4));
    for (int i = 0; i < NB4; i++) begin
      send4(q[i]);
      if (i < NB4 - 1) begin
        checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL basic_early_valid beat %0d: got %b expected 0", i, out_valid4); end
      end
    end
    in_valid4 = 1'b0;
    checks++; if (out_valid4 !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", out_valid4); end
    checks++; if (out_data4 !== exp) begin errors++; $display("FAIL basic_data: got %0d expected %0d", $signed(out_data4), $signed(exp)); end
    tick();
    checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL basic_pulse_width: got %b expected 0", out_valid4); end
  endtask

  task automatic test_sign_extreme();
    int q[$];
    logic [AW4-1:0] exp4;
    logic [AW9-1:0] exp9;
    q = '{-2048, 0, 0, 0};
    exp4 = AW4'(da_ref(q, NB4));
    foreach (q[i]) send4(q[i]);
    in_valid4 = 1'b0;
    checks++; if (out_valid4 !== 1'b1 || out_data4 !== exp4) begin errors++; $display("FAIL sign_min4: got valid=%b data=%0d expected valid=1 data=%0d", out_valid4, $signed(out_data4), $signed(exp4)); end
    tick();
    q = '{2047, 0, 0, 0, 0, 0, 0, 0, 0};
    exp9 = AW9'(da_ref(q, NB9));
    foreach (q[i]) send9(q[i]);
    in_valid9 = 1'b0;
    checks++; if (out_valid9 !== 1'b1 || out_data9 !== exp9) begin errors++; $display("FAIL sign_max9: got valid=%b data=%0d expected valid=1 data=%0d", out_valid9, $signed(out_data9), $signed(exp9)); end
    tick();
    checks++; if (out_valid9 !== 1'b0) begin errors++; $display("FAIL sign_max9_drop: got %b expected 0", out_valid9); end
  endtask

  task automatic test_backpressure();
    int q[$];
    logic [AW4-1:0] exp;
    q = '{3, 1, 0, 2};
    exp = AW4'(da_ref(q, NB4));
    out_ready4 = 1'b0;
    foreach (q[i]) send4(q[i]);
    // next sign-plane beat waits at the input while the result is held
    in_valid4 = 1'b1;
    in_pp4    = PPW'(5);
    for (int c = 0; c < 5; c++) begin
      checks++; if (out_valid4 !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cycle %0d: got %b expected 1", c, out_valid4); end
      checks++; if (in_ready4 !== 1'b0) begin errors++; $display("FAIL bp_in_ready cycle %0d: got %b expected 0", c, in_ready4); end
      checks++; if (out_data4 !== exp) begin errors++; $display("FAIL bp_hold_data cycle %0d: got %0d expected %0d", c, $signed(out_data4), $signed(exp)); end
      tick();
    end
    out_ready4 = 1'b1;
    #1;
    checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", in_ready4); end
    tick();
    checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b expected 0", out_valid4); end
    q = '{5, 0, 0, 0};
    exp = AW4'(da_ref(q, NB4));
    for (int i = 1; i < NB4; i++) send4(q[i]);
    in_valid4 = 1'b0;
    checks++; if (out_valid4 !== 1'b1 || out_data4 !== exp) begin errors++; $display("FAIL bp_next_result: got valid=%b data=%0d expected valid=1 data=%0d", out_valid4, $signed(out_data4), $signed(exp)); end
    tick();
  endtask

  task automatic test_bubbles();
    int q[$];
    logic [AW4-1:0] exp;
    int gaps;
    q = '{1, 2, 3, 4};
    exp = AW4'(da_ref(q, NB4));
    foreach (q[i]) begin
      gaps = int'($urandom_range(0, 3));
      in_valid4 = 1'b0;
      for (int g = 0; g < gaps; g++) begin
        in_pp4 = PPW'($urandom);
        tick();
        checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL bubble_valid: got %b expected 0", out_valid4); end
      end
      send4(q[i]);
    end
    in_valid4 = 1'b0;
    checks++; if (out_valid4 !== 1'b1 || out_data4 !== exp) begin errors++; $display("FAIL bubble_result: got valid=%b data=%0d expected valid=1 data=%0d", out_valid4, $signed(out_data4), $signed(exp)); end
    tick();
  endtask

  task automatic test_reset_midop();
    int q[$];
    logic [AW4-1:0] exp;
    send4(5);
    send4(6);
    in_valid4 = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", out_valid4); end
    checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b expected 1", in_ready4); end
    repeat (3) tick();
    checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL midrst_no_output: got %b expected 0", out_valid4); end
    q = '{0, 0, 0, 7};
    exp = AW4'(da_ref(q, NB4));
    foreach (q[i]) send4(q[i]);
    in_valid4 = 1'b0;
    checks++; if (out_valid4 !== 1'b1 || out_data4 !== exp) begin errors++; $display("FAIL midrst_fresh: got valid=%b data=%0d expected valid=1 data=%0d", out_valid4, $signed(out_data4), $signed(exp)); end
    tick();
  endtask

  task automatic test_throughput();
    int w[100];
    int q[$];
    logic [AW4-1:0] exp;
    int results;
    results = 0;
    out_ready4 = 1'b1;
    foreach (w[i]) w[i] = rand_pp();
    for (int k = 0; k < 100; k++) begin
      in_valid4 = 1'b1;
      in_pp4    = PPW'(w[k]);
      checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL tp_ready word %0d: got %b expected 1", k, in_ready4); end
      tick();
      if (k % NB4 == NB4 - 1) begin
        q = '{w[k-3], w[k-2], w[k-1], w[k]};
        exp = AW4'(da_ref(q, NB4));
        checks++; if (out_valid4 !== 1'b1 || out_data4 !== exp) begin errors++; $display("FAIL tp_result word %0d: got valid=%b data=%0d expected valid=1 data=%0d", k, out_valid4, $signed(out_data4), $signed(exp)); end
        if (out_valid4 === 1'b1) results++;
      end else begin
        checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL tp_idle_valid word %0d: got %b expected 0", k, out_valid4); end
      end
    end
    in_valid4 = 1'b0;
    tick();
    checks++; if (results !== 25) begin errors++; $display("FAIL tp_result_count: got %0d expected 25", results); end
  endtask

  task automatic test_back_to_back9();
    int q[$];
    logic [AW9-1:0] exp;
    out_ready9 = 1'b1;
    for (int r = 0; r < 4; r++) begin
      q = {};
      for (int i = 0; i < NB9; i++) q.push_back(rand_pp());
      exp = AW9'(da_ref(q, NB9));
      foreach (q[i]) send9(q[i]);
      checks++; if (out_valid9 !== 1'b1 || out_data9 !== exp) begin errors++; $display("FAIL b2b9_result %0d: got valid=%b data=%0d expected valid=1 data=%0d", r, out_valid9, $signed(out_data9), $signed(exp)); end
    end
    in_valid9 = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_sign_extreme();
    test_backpressure();
    test_bubbles();
    test_reset_midop();
    test_throughput();
    test_back_to_back9();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
